sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2, meaning the number of rising edges from new-address sample to valid read data; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 17, meaning the number of implemented address bits; legal range 1..17.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port SRAM_DQ  inout  32  data bus: written by the controller when SRAM_WE_N=0, driven by this block only in RDRIVE.
REQ-006 SHALL have port SRAM_ADDR  input  17  word address from the controller.
REQ-007 SHALL have port SRAM_WE_N  input  1  active-low write strobe.
REQ-008 SHALL have port rd_valid  output  1  high exactly while SRAM_DQ is driven with valid read data.
REQ-009 SHALL have port wr_count  output  16  number of completed write edges; wraps modulo 2^16.
REQ-010 SHALL have port rd_count  output  16  number of completed reads; wraps modulo 2^16.

Function
REQ-011 SHALL implement states IDLE, RWAIT, RDRIVE, WRITE and TURN, with registered addr_q (DEPTH_LOG2 bits) and a 4-bit latency counter cnt.
REQ-012 SHALL, at every rising edge with SRAM_WE_N=0 and rst=0, write SRAM_DQ into word SRAM_ADDR[DEPTH_LOG2-1:0] and increment wr_count, in every state.
REQ-013 SHALL ignore SRAM_ADDR bits at and above DEPTH_LOG2, so aliased addresses map to the same word.
REQ-014 SHALL transition from any state to WRITE on an edge where SRAM_WE_N=0.
REQ-015 SHALL, in IDLE with SRAM_WE_N=1, load addr_q from SRAM_ADDR, set cnt to 1 and go to RWAIT.
REQ-016 SHALL, in RWAIT with SRAM_WE_N=1 and SRAM_ADDR differing from addr_q, reload addr_q, set cnt to 1 and remain in RWAIT (latency restarts).
REQ-017 SHALL, in RWAIT with a stable address, go to RDRIVE if cnt equals READ_LATENCY and otherwise increment cnt; valid data is therefore present READ_LATENCY edges after the address is first sampled.
REQ-018 SHALL increment rd_count on each transition into RDRIVE.
REQ-019 SHALL, in RDRIVE, drive SRAM_DQ with word addr_q combinationally from the array and hold rd_valid=1.
REQ-020 SHALL, in RDRIVE, go to RWAIT (reload addr_q, cnt=1) on an address change with SRAM_WE_N=1, and otherwise remain in RDRIVE.
REQ-021 SHALL, in WRITE with SRAM_WE_N=1, go to TURN.
REQ-022 SHALL treat TURN as a one-cycle bus-turnaround state with SRAM_DQ undriven: it goes to WRITE if SRAM_WE_N=0, and otherwise to RWAIT loading addr_q from SRAM_ADDR with cnt=1.
REQ-023 SHALL hold SRAM_DQ at high impedance and rd_valid at 0 in every state other than RDRIVE.
REQ-024 SHALL never drive SRAM_DQ in a cycle where SRAM_WE_N=0; the combinational drive enable SHALL be gated by SRAM_WE_N.
REQ-025 SHALL return the newly written value when a read follows a write to the same address after TURN, with no stale data.

Reset
REQ-026 SHALL, while rst=1, immediately force state IDLE, addr_q=0, cnt=0, wr_count=0, rd_count=0, rd_valid=0 and SRAM_DQ to high impedance, with no clock required.
REQ-027 SHALL suppress array writes while rst=1 and SHALL preserve array contents across reset.
REQ-028 SHALL abandon a read in progress when reset asserts; after release the read restarts from IDLE with the full latency.

Structure
REQ-029 SHALL take ADDR_W=17, DATA_W=32 and the state enumeration from shared package sram_pkg, which is also used by the SRAM controller.
REQ-030 SHALL place storage in one sub-module, sram_resp_array, with 2^DEPTH_LOG2 x 32 words, a synchronous write port and an asynchronous read port; the FSM, counters and tristate logic stay in sram_responder.

Verification
REQ-031 SHALL cover: write 0xDEADBEEF to address 0x00010, then hold address 0x00010 with WE_N=1 -> TURN, then rd_valid high two edges after TURN exit with DQ=0xDEADBEEF; wr_count=1, rd_count=1.
REQ-032 SHALL cover: READ_LATENCY=2, address changed every edge for 5 edges -> rd_valid stays 0 and DQ stays Z throughout; rd_count=0.
REQ-033 SHALL cover: DEPTH_LOG2=4, write 0x12345678 at address 0x00003, then read address 0x00013 -> DQ=0x12345678 (aliasing).
REQ-034 SHALL cover: rst asserted mid-RWAIT between clock edges -> DQ goes Z and the counters go to 0 without a clock edge; after release, previously written data still reads back correctly.
REQ-035 SHALL cover: in RDRIVE, WE_N dropped with DQ=0xA5A5A5A5 -> the responder releases DQ in the same cycle (no X on DQ), and the word is written at that edge.
REQ-036 SHALL cover: 65536 write edges -> wr_count wraps to 0x0000.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM controller and the SRAM responder model:
// bus widths and the responder state encoding.
package sram_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    typedef logic [2:0] sram_state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RWAIT  = 3'd1;
    localparam logic [2:0] ST_RDRIVE = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_TURN   = 3'd4;

endpackage

// File: rtl/sram_resp_array.sv
// Word storage for the SRAM responder: synchronous write port, asynchronous read port.
// Contents are never reset.
module sram_resp_array
    import sram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 17
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sram_responder.sv
// Behavioural SRAM device on a shared tristate data bus: write on any low WE_N edge,
// read data driven READ_LATENCY edges after a stable address is sampled.
module sram_responder
    import sram_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int DEPTH_LOG2   = 17
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_WE_N,
    output logic              rd_valid,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);

    sram_state_t           r_state;
    logic [DEPTH_LOG2-1:0] r_addr_q;
    logic [3:0]            r_cnt;
    logic [15:0]           r_wr_count;
    logic [15:0]           r_rd_count;

    logic [DEPTH_LOG2-1:0] w_addr;
    logic                  w_addr_chg;
    logic                  w_we;
    logic                  w_drive;
    logic [DATA_W-1:0]     w_rdata;

    // Upper address bits are ignored, so aliased addresses hit the same word.
    assign w_addr     = SRAM_ADDR[DEPTH_LOG2-1:0];
    assign w_addr_chg = (w_addr != r_addr_q);
    assign w_we       = ~SRAM_WE_N & ~rst;

    sram_resp_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_addr),
        .i_wdata (SRAM_DQ),
        .i_raddr (r_addr_q),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr_q   <= '0;
            r_cnt      <= 4'd0;
            r_wr_count <= 16'd0;
            r_rd_count <= 16'd0;
        end else if (!SRAM_WE_N) begin
            r_wr_count <= r_wr_count + 16'd1;
            r_state    <= ST_WRITE;
        end else begin
            case (r_state)
                ST_IDLE, ST_TURN: begin
                    r_addr_q <= w_addr;
                    r_cnt    <= 4'd1;
                    r_state  <= ST_RWAIT;
                end
                ST_RWAIT: begin
                    if (w_addr_chg) begin
                        r_addr_q <= w_addr;
                        r_cnt    <= 4'd1;
                    end else if (r_cnt == 4'(READ_LATENCY)) begin
                        r_state    <= ST_RDRIVE;
                        r_rd_count <= r_rd_count + 16'd1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_RDRIVE: begin
                    if (w_addr_chg) begin
                        r_addr_q <= w_addr;
                        r_cnt    <= 4'd1;
                        r_state  <= ST_RWAIT;
                    end
                end
                ST_WRITE: r_state <= ST_TURN;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Gating on WE_N releases the bus in the same cycle the controller starts writing.
    assign w_drive  = (r_state == ST_RDRIVE) & SRAM_WE_N;
    assign SRAM_DQ  = w_drive ? w_rdata : {DATA_W{1'bz}};
    assign rd_valid = w_drive;
    assign wr_count = r_wr_count;
    assign rd_count = r_rd_count;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_sram_responder;

    localparam int RL1 = 2;

    logic        clk;
    logic        rst;

    logic        we_n1;
    logic [16:0] addr1;
    logic [31:0] drv1;
    wire  [31:0] dq1;
    logic        rd_valid1;
    logic [15:0] wr_count1;
    logic [15:0] rd_count1;

    logic        we_n2;
    logic [16:0] addr2;
    logic [31:0] drv2;
    wire  [31:0] dq2;
    logic        rd_valid2;
    logic [15:0] wr_count2;
    logic [15:0] rd_count2;

    int n_checks;
    int n_errors;

    assign dq1 = we_n1 ? 32'bz : drv1;
    assign dq2 = we_n2 ? 32'bz : drv2;

    sram_responder #(.READ_LATENCY(RL1), .DEPTH_LOG2(17)) dut1 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq1), .SRAM_ADDR(addr1), .SRAM_WE_N(we_n1),
        .rd_valid(rd_valid1), .wr_count(wr_count1), .rd_count(rd_count1)
    );

    sram_responder #(.READ_LATENCY(1), .DEPTH_LOG2(4)) dut2 (
        .clk(clk), .rst(rst), .SRAM_DQ(dq2), .SRAM_ADDR(addr2), .SRAM_WE_N(we_n2),
        .rd_valid(rd_valid2), .wr_count(wr_count2), .rd_count(rd_count2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // driver tasks
    task automatic drive1(input logic we_n, input logic [16:0] addr, input logic [31:0] data);
        we_n1 = we_n;
        addr1 = addr;
        drv1  = data;
    endtask

    task automatic drive2(input logic we_n, input logic [16:0] addr, input logic [31:0] data);
        we_n2 = we_n;
        addr2 = addr;
        drv2  = data;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference model: read timing as "edges since a stable address was sampled"
    logic [31:0] m_mem [int];
    logic [31:0] exp_q [$];
    int          m_age;
    int          m_turn;
    bit          m_sampled;
    logic [16:0] m_addr;
    int          m_wr;
    int          m_rd;

    task automatic model_reset();
        m_age = 0; m_turn = 0; m_sampled = 0; m_addr = '0; m_wr = 0; m_rd = 0;
        m_mem.delete();
        exp_q.delete();
    endtask

    task automatic model_edge(input logic we_n, input logic [16:0] addr, input logic [31:0] data);
        if (!we_n) begin
            m_mem[int'(addr)] = data;
            m_wr++;
            m_turn = 2;
            m_sampled = 0;
        end else if (m_turn == 2) begin
            m_turn = 1;
        end else if (m_turn == 1 || !m_sampled || addr != m_addr) begin
            m_turn = 0;
            m_sampled = 1;
            m_addr = addr;
            m_age = 1;
        end else if (m_age <= RL1) begin
            if (m_age == RL1) m_rd++;
            m_age++;
        end
    endtask

    typedef struct {
        logic        we_n;
        logic [16:0] addr;
        logic [31:0] data;
        logic        exp_valid;
        logic        chk_dq;
        logic [31:0] exp_dq;
        logic [15:0] exp_wr;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we_n, logic [16:0] addr, logic [31:0] data, logic ev,
                                logic cd, logic [31:0] edq, logic [15:0] ew, logic [15:0] er);
        vec_t v;
        v.we_n = we_n; v.addr = addr; v.data = data; v.exp_valid = ev;
        v.chk_dq = cd; v.exp_dq = edq; v.exp_wr = ew; v.exp_rd = er;
        return v;
    endfunction

    initial begin
        logic        exp_v;
        logic        r_we_n;
        logic [16:0] r_addr;
        logic [31:0] r_data;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        drive1(1'b1, 17'h0, 32'h0);
        drive2(1'b1, 17'h0, 32'h0);
        #2 rst = 1'b1;
        #1;
        check("reset wr_count", wr_count1, 16'h0);
        check("reset rd_count", rd_count1, 16'h0);
        check("reset rd_valid", rd_valid1, 1'b0);

        // write, turnaround, read; write during RDRIVE; read-after-write; address moves
        vecs.push_back(mk(0, 17'h10, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 1, 0));
        vecs.push_back(mk(1, 17'h10, 32'h0, 0, 0, 32'h0, 1, 0));
        vecs.push_back(mk(1, 17'h10, 32'h0, 0, 0, 32'h0, 1, 0));
        vecs.push_back(mk(1, 17'h10, 32'h0, 0, 0, 32'h0, 1, 0));
        vecs.push_back(mk(1, 17'h10, 32'h0, 1, 1, 32'hDEADBEEF, 1, 1));
        vecs.push_back(mk(1, 17'h10, 32'h0, 1, 1, 32'hDEADBEEF, 1, 1));
        vecs.push_back(mk(0, 17'h10, 32'hA5A5A5A5, 0, 1, 32'hA5A5A5A5, 2, 1));
        vecs.push_back(mk(1, 17'h10, 32'h0, 0, 0, 32'h0, 2, 1));
        vecs.push_back(mk(1, 17'h10, 32'h0, 0, 0, 32'h0, 2, 1));
        vecs.push_back(mk(1, 17'h10, 32'h0, 0, 0, 32'h0, 2, 1));
        vecs.push_back(mk(1, 17'h10, 32'h0, 1, 1, 32'hA5A5A5A5, 2, 2));
        vecs.push_back(mk(1, 17'h11, 32'h0, 0, 0, 32'h0, 2, 2));
        vecs.push_back(mk(1, 17'h10, 32'h0, 0, 0, 32'h0, 2, 2));
        vecs.push_back(mk(1, 17'h10, 32'h0, 0, 0, 32'h0, 2, 2));
        vecs.push_back(mk(1, 17'h10, 32'h0, 1, 1, 32'hA5A5A5A5, 2, 3));

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive1(vecs[i].we_n, vecs[i].addr, vecs[i].data);
            #1;
            if (!vecs[i].we_n) begin
                check($sformatf("vec%0d release valid", i), rd_valid1, 1'b0);
                check($sformatf("vec%0d release dq", i), dq1, vecs[i].data);
            end
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d valid", i), rd_valid1, vecs[i].exp_valid);
            if (vecs[i].chk_dq) check($sformatf("vec%0d dq", i), dq1, vecs[i].exp_dq);
            check($sformatf("vec%0d wr_count", i), wr_count1, vecs[i].exp_wr);
            check($sformatf("vec%0d rd_count", i), rd_count1, vecs[i].exp_rd);
        end

        // reset in the middle of RWAIT, without a clock edge; writes blocked while in reset
        drive1(1'b1, 17'h05, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rwait valid", rd_valid1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async rst wr_count", wr_count1, 16'h0);
        check("async rst rd_count", rd_count1, 16'h0);
        check("async rst valid", rd_valid1, 1'b0);
        drive1(1'b0, 17'h10, 32'hFFFFFFFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in rst wr_count", wr_count1, 16'h0);
        drive1(1'b1, 17'h10, 32'h0);
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = (e == RL1 + 1);
            check($sformatf("post rst edge%0d valid", e), rd_valid1, exp_v);
            check($sformatf("post rst edge%0d rd_count", e), rd_count1, {15'h0, exp_v});
            if (exp_v) check("post rst data kept", dq1, 32'hA5A5A5A5);
        end

        // address moving every edge never completes a read
        drive1(1'b1, 17'h20, 32'h0);
        do_reset();
        for (int e = 0; e < 5; e++) begin
            drive1(1'b1, 17'h20 + 17'(e), 32'h0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("addr walk %0d valid", e), rd_valid1, 1'b0);
        end
        check("addr walk rd_count", rd_count1, 16'h0);

        // aliasing on the 4-bit-deep, latency-1 instance
        drive2(1'b0, 17'h00003, 32'h12345678);
        do_reset();
        @(posedge clk);
        @(negedge clk);
        drive2(1'b1, 17'h00013, 32'h0);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = (e == 3);
            check($sformatf("alias edge%0d valid", e), rd_valid2, exp_v);
        end
        check("alias dq", dq2, 32'h12345678);
        check("alias wr_count", wr_count2, 16'h1);
        check("alias rd_count", rd_count2, 16'h1);

        // write counter wrap
        drive1(1'b0, 17'h00040, $urandom);
        do_reset();
        repeat (65535) @(posedge clk);
        @(negedge clk);
        check("wr_count max", wr_count1, 16'hFFFF);
        @(posedge clk);
        @(negedge clk);
        check("wr_count wrap", wr_count1, 16'h0000);
        check("wrap rd_count", rd_count1, 16'h0);

        // randomized traffic against the reference model
        drive1(1'b1, 17'h0, 32'h0);
        do_reset();
        model_reset();
        r_addr = 17'h0;
        for (int c = 0; c < 2000; c++) begin
            r_we_n = ($urandom_range(0, 99) < 15) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 4) == 0) r_addr = 17'($urandom_range(0, 7));
            r_data = $urandom;
            drive1(r_we_n, r_addr, r_data);
            @(posedge clk);
            model_edge(r_we_n, r_addr, r_data);
            exp_v = r_we_n && m_sampled && (m_age == RL1 + 1);
            if (exp_v && m_mem.exists(int'(m_addr))) exp_q.push_back(m_mem[int'(m_addr)]);
            @(negedge clk);
            check($sformatf("rand%0d valid", c), rd_valid1, exp_v);
            check($sformatf("rand%0d wr_count", c), wr_count1, 16'(m_wr));
            check($sformatf("rand%0d rd_count", c), rd_count1, 16'(m_rd));
            if (!r_we_n) check($sformatf("rand%0d write bus", c), dq1, r_data);
            if (exp_q.size() > 0) check($sformatf("rand%0d read data", c), dq1, exp_q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
